// File: rtl/lsu_unit.sv
// lsu_unit: multi-cycle RV32I load/store unit on a req/gnt/rvalid data bus.
// Takes the ALU result as effective address, stalls the core until the access
// completes, and returns aligned, sign/zero-extended load data.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/we/funct3/addr/wdata   memory op from execute stage
//   lsu_stall                        combinational stall to the core
//   rd_valid, rd_data                load-complete pulse and extended data
//   misalign                         misaligned-access pulse (trap build only)
//   mem_req/we/addr/be/wdata         bus request side
//   mem_gnt, mem_rvalid, mem_rdata   bus response side
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no bus op, misalign pulse). Otherwise the address is forced
// aligned to the access size and misalign is tied low.
module lsu_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              lsu_stall,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              byte_q, byte_d;
  logic              half_q, half_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;

  logic              is_byte_c, is_half_c;
  logic [1:0]        off_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [7:0]        lane_b_c;
  logic [15:0]       lane_h_c;
  logic [31:0]       ld_ext_c;

  assign is_byte_c = (req_funct3[1:0] == 2'b00);
  assign is_half_c = (req_funct3[1:0] == 2'b01);

  // Request decode: offset forced to access-size alignment, lanes, replication
  always_comb begin
    off_c   = 2'b00;
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    if (is_byte_c) begin
      off_c   = req_addr[1:0];
      be_c    = 4'b0001 << off_c;
      wdata_c = {4{req_wdata[7:0]}};
    end else if (is_half_c) begin
      off_c   = {req_addr[1], 1'b0};
      be_c    = 4'b0011 << off_c;
      wdata_c = {2{req_wdata[15:0]}};
    end
  end

  // Load data: pick lane using the offset captured at request time, then extend
  always_comb begin
    case (off_q)
      2'd1:    lane_b_c = mem_rdata[15:8];
      2'd2:    lane_b_c = mem_rdata[23:16];
      2'd3:    lane_b_c = mem_rdata[31:24];
      default: lane_b_c = mem_rdata[7:0];
    endcase
    lane_h_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (byte_q) begin
      ld_ext_c = {{24{~uns_q & lane_b_c[7]}}, lane_b_c};
    end else if (half_q) begin
      ld_ext_c = {{16{~uns_q & lane_h_c[15]}}, lane_h_c};
    end else begin
      ld_ext_c = mem_rdata;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic misaligned_c;
  assign misaligned_c = (is_half_c & req_addr[0]) |
                        (~is_byte_c & ~is_half_c & (req_addr[1:0] != 2'b00));
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    byte_d      = byte_q;
    half_d      = half_q;
    uns_d       = uns_q;
    off_d       = off_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = be_c;
          mem_wdata_d = wdata_c;
          byte_d      = is_byte_c;
          half_d      = is_half_c;
          uns_d       = req_funct3[2];
          off_d       = off_c;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned_c) begin
            state_d    = S_DONE;
            misalign_d = 1'b1;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
          end
`else
          state_d   = S_REQ;
          mem_req_d = 1'b1;
`endif
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? S_DONE : S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          rd_data_d  = ld_ext_c;
          rd_valid_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rd_data_q   <= 32'h0;
      rd_valid_q  <= 1'b0;
      byte_q      <= 1'b0;
      half_q      <= 1'b0;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      byte_q      <= byte_d;
      half_q      <= half_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign lsu_stall = req_valid & (state_q != S_DONE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit with a load-result scoreboard and a
// bench-driven memory responder (configurable gnt/rvalid delays).
module tb_lsu_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        lsu_stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd  = 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  lsu_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .lsu_stall  (lsu_stall),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Issue one op in the current IDLE cycle, act as memory, check the result.
  task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int gnt_d, input int rv_d, input logic [31:0] rdata,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                       input logic exp_mis, input logic junk);
    int cyc, rc, rw, exp_cyc, exp_req;
    logic granted, done, exp_rdv;
    exp_rdv = !we && !exp_mis;
    exp_req = exp_mis ? 0 : gnt_d + 1;
    exp_cyc = exp_mis ? 2 : ((we ? 3 : 4 + rv_d) + gnt_d);
    if (exp_rdv) exp_q.push_back(exp_rd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    chk({name, ".stall_c1"}, 32'(lsu_stall), 32'd1);
    cyc = 1; rc = 0; rw = 0; granted = 1'b0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (lsu_stall === 1'b0) begin
        done = 1'b1;
      end else if (mem_req === 1'b1) begin
        rc++;
        chk({name, ".addr"}, mem_addr, exp_addr);
        chk({name, ".be"}, 32'(mem_be), 32'(exp_be));
        chk({name, ".we"}, 32'(mem_we), 32'(we));
        if (we) chk({name, ".wdata"}, mem_wdata, exp_wdata);
        if (rc > gnt_d) begin
          mem_gnt = 1'b1; granted = 1'b1;
        end else if (junk) begin
          mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
        end
      end else if (granted && !we) begin
        rw++;
        if (rw > rv_d) begin
          mem_rvalid = 1'b1; mem_rdata = rdata;
        end else if (junk) begin
          mem_gnt = 1'b1;
        end
      end
    end
    if (!done) chk({name, ".timeout"}, 32'(done), 32'd1);
    chk({name, ".cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({name, ".req_cycles"}, 32'(rc), 32'(exp_req));
    chk({name, ".rd_valid"}, 32'(rd_valid), 32'(exp_rdv));
    chk({name, ".misalign"}, 32'(misalign), 32'(exp_mis));
    if (rd_valid === 1'b1 && exp_q.size() > 0) begin
      last_rd = exp_q.pop_front();
      chk({name, ".rd_data"}, rd_data, last_rd);
    end else begin
      chk({name, ".rd_hold"}, rd_data, last_rd);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, ".rd_valid_pulse"}, 32'(rd_valid), 32'd0);
    chk({name, ".misalign_pulse"}, 32'(misalign), 32'd0);
    chk({name, ".req_idle"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #2;
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.rd_data", rd_data, 32'h0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.misalign", 32'(misalign), 32'd0);
    req_valid = 1'b1; #1;
    chk("rst.stall_hi", 32'(lsu_stall), 32'd1);
    req_valid = 1'b0; #1;
    chk("rst.stall_lo", 32'(lsu_stall), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    //    name     we    f3      addr          wdata         g  r  rdata         exp_addr      be       exp_wdata     exp_rd        mis  junk
    do_op("sw",    1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0000_0100, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
    do_op("lb",    1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 0, 32'h80123456, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0);
    do_op("lbu",   1'b0, 3'b100, 32'h0000_0103, 32'h0,        0, 0, 32'h80123456, 32'h0000_0100, 4'b1000, 32'h0,        32'h00000080, 1'b0, 1'b0);
    do_op("sh",    1'b1, 3'b001, 32'h0000_0102, 32'h0000BEEF, 3, 0, 32'h0,        32'h0000_0100, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b1);
    do_op("lh",    1'b0, 3'b001, 32'h0000_0102, 32'h0,        1, 2, 32'h80017FFF, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0, 1'b1);
    do_op("lhu",   1'b0, 3'b101, 32'h0000_0100, 32'h0,        0, 0, 32'h1234F00D, 32'h0000_0100, 4'b0011, 32'h0,        32'h0000F00D, 1'b0, 1'b0);
    do_op("sb",    1'b1, 3'b000, 32'h0000_0101, 32'h000000A5, 0, 0, 32'h0,        32'h0000_0100, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0);
    do_op("lw_mis", 1'b0, 3'b010, 32'h0000_0201, 32'h0,       0, 0, 32'hCAFEF00D, 32'h0000_0200, 4'b1111, 32'h0,        32'hCAFEF00D, TRAP, 1'b0);
    do_op("lh_mis", 1'b0, 3'b001, 32'h0000_0103, 32'h0,       0, 0, 32'h7FFF0000, 32'h0000_0100, 4'b1100, 32'h0,        32'h00007FFF, TRAP, 1'b0);
    do_op("lb2",   1'b0, 3'b000, 32'h0000_0102, 32'h0,        0, 1, 32'h00FF0000, 32'h0000_0100, 4'b0100, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0);

    // Reset in WAIT_R, then a late rvalid that must be ignored
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
    @(posedge clk); #1;
    chk("rstw.req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rstw.wait_r", 32'(mem_req), 32'd0);
    rst_n = 1'b0; req_valid = 1'b0; #1;
    chk("rstw.mem_req", 32'(mem_req), 32'd0);
    chk("rstw.rd_valid", 32'(rd_valid), 32'd0);
    chk("rstw.rd_data", rd_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("rstw.late_rvalid", 32'(rd_valid), 32'd0);
    chk("rstw.late_rd_data", rd_data, 32'h0);
    chk("rstw.late_req", 32'(mem_req), 32'd0);
    last_rd = 32'h0;
    do_op("lw_post", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 0, 0, 32'h11223344, 32'h0000_0300, 4'b1111, 32'h0, 32'h11223344, 1'b0, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
